// File: rtl/scratchpad_mem_if.sv
// Load/store bus between the CPU load/store unit and the data scratchpad.
// The master drives read/write requests; the slave returns the registered read word.
interface scratchpad_mem_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   spm_rdaddress;
  logic                    spm_rden;
  logic [ADDR_WIDTH-1:0]   spm_wraddress;
  logic                    spm_wren;
  logic [DATA_WIDTH-1:0]   spm_write_data;
  logic [DATA_WIDTH/8-1:0] spm_store_byteena;
  logic [DATA_WIDTH-1:0]   spm_rd_data;

  modport master (
    output spm_rdaddress, spm_rden, spm_wraddress, spm_wren,
           spm_write_data, spm_store_byteena,
    input  spm_rd_data
  );

  modport slave (
    input  spm_rdaddress, spm_rden, spm_wraddress, spm_wren,
           spm_write_data, spm_store_byteena,
    output spm_rd_data
  );
endinterface

// File: rtl/scratchpad_mem.sv
// Data scratchpad for the CPU core: one byte-masked write port and one
// registered read port, both accepting a request every cycle.
// Compile-time option: define SPM_BYPASS_EN to return the freshly merged word
// when a read and a write hit the same index in the same cycle (write-first);
// without it the read returns the old word (read-first).
// The storage array has no reset; only the read data register is cleared.
module scratchpad_mem #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  scratchpad_mem_if.slave   spm
);
  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int NUM_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Write qualifier: a write landing on an edge while reset is held is dropped
  // so that reset can never corrupt stored data.
  always_comb begin
    wr_en = spm.spm_wren & rst_n;
  end

  // Byte-masked write; bytes with a clear enable keep their previous value.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (spm.spm_store_byteena[i]) begin
          mem[spm.spm_wraddress][i*8 +: 8] <= spm.spm_write_data[i*8 +: 8];
        end
      end
    end
  end

  // Read word selection (with optional same-index merge) and hold when idle.
  always_comb begin
    rd_word = mem[spm.spm_rdaddress];
`ifdef SPM_BYPASS_EN
    if (wr_en && spm.spm_rden && (spm.spm_rdaddress == spm.spm_wraddress)) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (spm.spm_store_byteena[i]) begin
          rd_word[i*8 +: 8] = spm.spm_write_data[i*8 +: 8];
        end
      end
    end
`endif
    rd_data_d = rd_data_q;
    if (spm.spm_rden) begin
      rd_data_d = rd_word;
    end
  end

  // Read data register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign spm.spm_rd_data = rd_data_q;
endmodule

// File: tb/tb_scratchpad_mem.sv
// Self-checking bench for scratchpad_mem: expected read words are queued when
// a read request is driven and compared after the edge that samples it.
module tb_scratchpad_mem;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [31:0] exp_q [$];

  scratchpad_mem_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) spm_bus ();

  scratchpad_mem #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .spm   (spm_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of requests at the falling edge, run through the next
  // rising edge, and return at the following falling edge.
  task automatic drive(input logic wr, input logic [9:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic rd, input logic [9:0] ra,
                       input logic [31:0] rd_exp);
    spm_bus.spm_wren          = wr;
    spm_bus.spm_wraddress     = wa;
    spm_bus.spm_write_data    = wd;
    spm_bus.spm_store_byteena = be;
    spm_bus.spm_rden          = rd;
    spm_bus.spm_rdaddress     = ra;
    if (rd) exp_q.push_back(rd_exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 10'd0, 32'd0, 4'h0, 1'b0, 10'd0, 32'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    spm_bus.spm_rden          = 1'b1;
    spm_bus.spm_rdaddress     = 10'd0;
    spm_bus.spm_wren          = 1'b0;
    spm_bus.spm_wraddress     = 10'd0;
    spm_bus.spm_write_data    = 32'd0;
    spm_bus.spm_store_byteena = 4'h0;
    #1;
    checks++;
    if (spm_bus.spm_rd_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_hold: got %h expected %h", spm_bus.spm_rd_data, 32'h0);
    end
    #2;
    rst_n = 1'b1;
    spm_bus.spm_rden = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (spm_bus.spm_rd_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_first_edge: got %h expected %h", spm_bus.spm_rd_data, 32'h0);
    end
    $display("reset: rd_data=%h", spm_bus.spm_rd_data);
    @(negedge clk);
  endtask

  task automatic test_full_word();
    logic [31:0] e;
    drive(1'b1, 10'd5, 32'hDEADBEEF, 4'hF, 1'b0, 10'd0, 32'd0);
    drive(1'b0, 10'd0, 32'd0, 4'h0, 1'b1, 10'd5, 32'hDEADBEEF);
    checks++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    if (spm_bus.spm_rd_data !== e) begin
      failures++;
      $display("FAIL full_word_read: got %h expected %h", spm_bus.spm_rd_data, e);
    end
    $display("full_word: read idx 5 -> %h", spm_bus.spm_rd_data);
    idle();
    idle();
    checks++;
    if (spm_bus.spm_rd_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL full_word_hold: got %h expected %h", spm_bus.spm_rd_data, 32'hDEADBEEF);
    end
  endtask

  task automatic test_byte_enables();
    logic [31:0] e;
    drive(1'b1, 10'd7, 32'h11223344, 4'hF, 1'b0, 10'd0, 32'd0);
    drive(1'b1, 10'd7, 32'hAABBCCDD, 4'b0101, 1'b0, 10'd0, 32'd0);
    drive(1'b0, 10'd0, 32'd0, 4'h0, 1'b1, 10'd7, 32'h11BB33DD);
    checks++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    if (spm_bus.spm_rd_data !== e) begin
      failures++;
      $display("FAIL byte_merge: got %h expected %h", spm_bus.spm_rd_data, e);
    end
    $display("byte_enables: merged read idx 7 -> %h", spm_bus.spm_rd_data);
    // wren=1 with no enables, then enables set but wren=0: both must be no-ops
    drive(1'b1, 10'd7, 32'hFFFFFFFF, 4'h0, 1'b0, 10'd0, 32'd0);
    drive(1'b0, 10'd7, 32'h00000000, 4'hF, 1'b0, 10'd0, 32'd0);
    drive(1'b0, 10'd0, 32'd0, 4'h0, 1'b1, 10'd7, 32'h11BB33DD);
    checks++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    if (spm_bus.spm_rd_data !== e) begin
      failures++;
      $display("FAIL byte_noop_write: got %h expected %h", spm_bus.spm_rd_data, e);
    end
    $display("byte_enables: after no-op writes idx 7 -> %h", spm_bus.spm_rd_data);
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 10'(k), 32'(k) * 32'h01010101, 4'hF, 1'b0, 10'd0, 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 10'd0, 32'd0, 4'h0, 1'b1, 10'(k), 32'(k) * 32'h01010101);
      checks++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
      if (spm_bus.spm_rd_data !== e) begin
        failures++;
        $display("FAIL stream_read_%0d: got %h expected %h", k, spm_bus.spm_rd_data, e);
      end
      $display("back_to_back: read idx %0d -> %h", k, spm_bus.spm_rd_data);
    end
  endtask

  task automatic test_collision();
    logic [31:0] e;
    logic [31:0] coll_exp;
`ifdef SPM_BYPASS_EN
    coll_exp = 32'hCAFE5678;
`else
    coll_exp = 32'hCAFEF00D;
`endif
    drive(1'b1, 10'd9, 32'hCAFEF00D, 4'hF, 1'b0, 10'd0, 32'd0);
    drive(1'b1, 10'd9, 32'h12345678, 4'b0011, 1'b1, 10'd9, coll_exp);
    checks++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    if (spm_bus.spm_rd_data !== e) begin
      failures++;
      $display("FAIL collision_read: got %h expected %h", spm_bus.spm_rd_data, e);
    end
    $display("collision: same-cycle read idx 9 -> %h", spm_bus.spm_rd_data);
    // Next read sees the completed write; a write elsewhere in the same cycle
    // must not disturb it.
    drive(1'b1, 10'd10, 32'h55555555, 4'hF, 1'b1, 10'd9, 32'hCAFE5678);
    checks++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    if (spm_bus.spm_rd_data !== e) begin
      failures++;
      $display("FAIL collision_after: got %h expected %h", spm_bus.spm_rd_data, e);
    end
    $display("collision: follow-up read idx 9 -> %h", spm_bus.spm_rd_data);
    drive(1'b0, 10'd0, 32'd0, 4'h0, 1'b1, 10'd10, 32'h55555555);
    checks++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    if (spm_bus.spm_rd_data !== e) begin
      failures++;
      $display("FAIL independent_write: got %h expected %h", spm_bus.spm_rd_data, e);
    end
    $display("collision: read idx 10 -> %h", spm_bus.spm_rd_data);
  endtask

  task automatic test_wrap_reset_retention();
    logic [31:0] e;
    drive(1'b1, 10'd1023, 32'h0000ABCD, 4'hF, 1'b0, 10'd0, 32'd0);
    drive(1'b0, 10'd0, 32'd0, 4'h0, 1'b1, 10'd1023, 32'h0000ABCD);
    checks++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    if (spm_bus.spm_rd_data !== e) begin
      failures++;
      $display("FAIL wrap_read: got %h expected %h", spm_bus.spm_rd_data, e);
    end
    $display("wrap: read idx 1023 -> %h", spm_bus.spm_rd_data);
    // Reset pulse with a write request pending: the write must be dropped.
    spm_bus.spm_wren          = 1'b1;
    spm_bus.spm_wraddress     = 10'd1023;
    spm_bus.spm_write_data    = 32'hFFFFFFFF;
    spm_bus.spm_store_byteena = 4'hF;
    spm_bus.spm_rden          = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (spm_bus.spm_rd_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_pulse_clear: got %h expected %h", spm_bus.spm_rd_data, 32'h0);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    spm_bus.spm_wren = 1'b0;
    $display("wrap: reset pulse rd_data=%h", spm_bus.spm_rd_data);
    drive(1'b0, 10'd0, 32'd0, 4'h0, 1'b1, 10'd1023, 32'h0000ABCD);
    checks++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    if (spm_bus.spm_rd_data !== e) begin
      failures++;
      $display("FAIL reset_retention: got %h expected %h", spm_bus.spm_rd_data, e);
    end
    $display("wrap: post-reset read idx 1023 -> %h", spm_bus.spm_rd_data);
    drive(1'b0, 10'd0, 32'd0, 4'h0, 1'b1, 10'd5, 32'hDEADBEEF);
    checks++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    if (spm_bus.spm_rd_data !== e) begin
      failures++;
      $display("FAIL reset_retention_idx5: got %h expected %h", spm_bus.spm_rd_data, e);
    end
    $display("wrap: post-reset read idx 5 -> %h", spm_bus.spm_rd_data);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_full_word();
    test_byte_enables();
    test_back_to_back();
    test_collision();
    test_wrap_reset_retention();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
